balise_axil_regbank: RTL and testbench

- Parametrised AXI4-Lite slave register bank for the beacon (balise) IP.
- Next generation of the fixed four-register beacon slave.
- Provides NUM_RW software-writable control words and NUM_RO read-only status words captured from beacon hardware.
- Adds byte strobes, SLVERR decode, a write-1-to-clear change-interrupt register and an interrupt output toward the PS.

---
 rtl/balise_axil_regbank_if.sv | 38 +++
 rtl/balise_axil_regbank.sv | 187 ++++++++++++++++++
 tb/tb_balise_axil_regbank.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/balise_axil_regbank_if.sv
// AXI4-Lite bus bundle for the beacon register bank.
// The master modport is the PS side; the slave modport is the register bank.
interface balise_axil_regbank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/balise_axil_regbank.sv
// AXI4-Lite register bank for the beacon IP: RW control words, synchronised
// RO status words, a W1C change-interrupt register and its enable mask.
module balise_axil_regbank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_RW             = 4,
  parameter int          NUM_RO             = 2,
  parameter logic [31:0] RW_RESET_VAL       = 32'h0
) (
  input  logic                                  s00_axi_aclk,
  input  logic                                  s00_axi_aresetn,
  balise_axil_regbank_if.slave                  s00_axi,
  input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]  status_in,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0]  ctrl_out,
  output logic                                  irq
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] RO_BASE  = IDX_W'(NUM_RW);
  localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(NUM_RW + NUM_RO);
  localparam logic [IDX_W-1:0] EN_IDX   = IDX_W'(NUM_RW + NUM_RO + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]   cur,
                                               input logic [DW-1:0]   wd,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = cur;
    for (int b = 0; b < DW/8; b++) begin
      if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  logic              awready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DW-1:0]     rdata_q;

  logic [DW-1:0]     rw_q [NUM_RW];
  logic [NUM_RO-1:0] irq_stat_q;
  logic [NUM_RO-1:0] irq_en_q;
  logic              irq_q;

  logic [NUM_RO*DW-1:0] sync_p0;
  logic [NUM_RO*DW-1:0] sync_p1;
  logic [NUM_RO*DW-1:0] prev_p2;

  logic [IDX_W-1:0]  aw_idx;
  logic [IDX_W-1:0]  ar_idx;
  logic              wr_fire;
  logic              wr_err;
  logic              rd_fire;
  logic [DW-1:0]     rd_data_d;
  logic              rd_err_d;
  logic [NUM_RO-1:0] chg;
  logic [NUM_RO-1:0] irq_stat_d;
  logic [NUM_RO-1:0] irq_en_d;

  logic unused_bits;
  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  assign aw_idx  = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx  = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  // awready is only raised while both AW and W are presented, so the
  // handshake completes in the cycle it is high.
  assign wr_fire = awready_q & s00_axi.awvalid & s00_axi.wvalid;
  assign rd_fire = arready_q & s00_axi.arvalid;
  assign wr_err  = ((aw_idx >= RO_BASE) && (aw_idx < STAT_IDX)) || (aw_idx > EN_IDX);

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = awready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rresp   = rresp_q;
  assign s00_axi.rdata   = rdata_q;
  assign irq             = irq_q;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_out[g*DW +: DW] = rw_q[g];
  end

  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    if (ar_idx < RO_BASE) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (ar_idx == IDX_W'(i)) rd_data_d = rw_q[i];
      end
    end else if (ar_idx < STAT_IDX) begin
      for (int k = 0; k < NUM_RO; k++) begin
        if (ar_idx == IDX_W'(NUM_RW + k)) rd_data_d = sync_p1[k*DW +: DW];
      end
    end else if (ar_idx == STAT_IDX) begin
      rd_data_d = DW'(irq_stat_q);
    end else if (ar_idx == EN_IDX) begin
      rd_data_d = DW'(irq_en_q);
    end else begin
      rd_err_d = 1'b1;
    end
  end

  // A hardware set is applied after the W1C so that it wins on collision.
  always_comb begin
    irq_stat_d = irq_stat_q;
    irq_en_d   = irq_en_q;
    for (int k = 0; k < NUM_RO; k++) begin
      chg[k] = |(sync_p1[k*DW +: DW] ^ prev_p2[k*DW +: DW]);
      if (wr_fire && (aw_idx == STAT_IDX) && s00_axi.wdata[k] && s00_axi.wstrb[k/8])
        irq_stat_d[k] = 1'b0;
      if (wr_fire && (aw_idx == EN_IDX) && s00_axi.wstrb[k/8])
        irq_en_d[k] = s00_axi.wdata[k];
      if (chg[k]) irq_stat_d[k] = 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      if (!bvalid_q && !awready_q && s00_axi.awvalid && s00_axi.wvalid)
        awready_q <= 1'b1;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s00_axi.bready) begin
        bvalid_q <= 1'b0;
      end
      if (!rvalid_q && !arready_q && s00_axi.arvalid)
        arready_q <= 1'b1;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_d;
        rresp_q  <= rd_err_d ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && s00_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= RW_RESET_VAL;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_fire && (aw_idx == IDX_W'(i)))
          rw_q[i] <= apply_strb(rw_q[i], s00_axi.wdata, s00_axi.wstrb);
      end
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  // Stage p0/p1: two-flop synchroniser; stage p2: previous value for change detect
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      sync_p0 <= status_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

endmodule

// File: tb/tb_balise_axil_regbank.sv
// Directed bench for balise_axil_regbank: register access, strobes, SLVERR,
// interrupt path, back-pressure and reset during an open response.
module tb_balise_axil_regbank;

  logic         clk;
  logic         aresetn;
  logic [63:0]  status_in;
  logic [127:0] ctrl_out;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  balise_axil_regbank_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  balise_axil_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_RW(4),
    .NUM_RO(2),
    .RW_RESET_VAL(32'h0)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi         (bus.slave),
    .status_in       (status_in),
    .ctrl_out        (ctrl_out),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic aw_issue(input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat);
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.awready && lat < 20);
    check_eq("aw_accept", {bus.awready, bus.wready}, 2'b11);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] resp);
    int n;
    n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("b_valid", bus.bvalid, 1'b1);
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic ar_issue(input logic [5:0] a);
    int n;
    n = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.arready && n < 20);
    check_eq("ar_accept", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic r_take(output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    bus.rready = 1'b1;
    while (!bus.rvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("r_valid", bus.rvalid, 1'b1);
    d    = bus.rdata;
    resp = bus.rresp;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int lat;
    aw_issue(a, d, s, lat);
    b_take(resp);
  endtask

  task automatic read_reg(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    ar_issue(a);
    r_take(d, resp);
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;
  logic [31:0] held;
  int          lat;
  logic        saw;
  logic [31:0] exp_vals [4] = '{32'h1, 32'h2, 32'h3, 32'h4};

  initial begin
    aresetn     = 1'b0;
    status_in   = '0;
    bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check_eq("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
    check_eq("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 36'h0);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_ctrl_lo", ctrl_out[63:0], 64'h0);
    check_eq("rst_ctrl_hi", ctrl_out[127:64], 64'h0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Full-word writes and readback
    aw_issue(6'h00, 32'h1, 4'hF, lat);
    check_eq("aw_latency", lat, 1);
    check_eq("b_after_hs", bus.bvalid, 1'b1);
    b_take(rsp);
    check_eq("bresp_w0", rsp, 2'b00);
    for (int i = 1; i < 4; i++) begin
      write_reg(6'(i*4), exp_vals[i], 4'hF, rsp);
      check_eq("bresp_wn", rsp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(6'(i*4), rd, rsp);
      check_eq("rd_rw", rd, exp_vals[i]);
      check_eq("rresp_rw", rsp, 2'b00);
    end
    check_eq("ctrl_out_w0", ctrl_out[31:0], 32'h1);
    check_eq("ctrl_out_w3", ctrl_out[127:96], 32'h4);

    // Byte strobes
    write_reg(6'h04, 32'hAABBCCDD, 4'b0101, rsp);
    check_eq("bresp_strb", rsp, 2'b00);
    read_reg(6'h04, rd, rsp);
    check_eq("rd_strb", rd, 32'h00BB00DD);

    // SLVERR on RO and unmapped
    write_reg(6'h10, 32'hFFFFFFFF, 4'hF, rsp);
    check_eq("bresp_ro", rsp, 2'b10);
    read_reg(6'h10, rd, rsp);
    check_eq("rd_ro_unchanged", rd, 32'h0);
    check_eq("rresp_ro", rsp, 2'b00);
    write_reg(6'h24, 32'h12345678, 4'hF, rsp);
    check_eq("bresp_unmapped", rsp, 2'b10);
    read_reg(6'h24, rd, rsp);
    check_eq("rd_unmapped", rd, 32'h0);
    check_eq("rresp_unmapped", rsp, 2'b10);
    check_eq("ctrl_after_err", ctrl_out, {32'h4, 32'h3, 32'h00BB00DD, 32'h1});
    read_reg(6'h1C, rd, rsp);
    check_eq("irq_en_unchanged", rd, 32'h0);

    // Interrupt path
    write_reg(6'h1C, 32'hFFFFFFFF, 4'hF, rsp);
    check_eq("bresp_irq_en", rsp, 2'b00);
    read_reg(6'h1C, rd, rsp);
    check_eq("rd_irq_en_masked", rd, 32'h3);
    status_in[31:0] = 32'h5;
    repeat (3) @(posedge clk);
    #1;
    check_eq("irq_3cyc", irq, 1'b0);
    @(posedge clk); #1;
    check_eq("irq_4cyc", irq, 1'b1);
    read_reg(6'h18, rd, rsp);
    check_eq("rd_irq_stat", rd, 32'h1);
    read_reg(6'h10, rd, rsp);
    check_eq("rd_status0", rd, 32'h5);
    write_reg(6'h18, 32'h1, 4'h0, rsp);
    read_reg(6'h18, rd, rsp);
    check_eq("w1c_no_strb", rd, 32'h1);
    write_reg(6'h18, 32'h1, 4'hF, rsp);
    check_eq("irq_cleared", irq, 1'b0);
    read_reg(6'h18, rd, rsp);
    check_eq("rd_irq_stat_clr", rd, 32'h0);

    // Write back-pressure: second AW+W must wait for B
    aw_issue(6'h08, 32'h11, 4'hF, lat);
    bus.awaddr  = 6'h0C;
    bus.wdata   = 32'h22;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_bvalid_hold", bus.bvalid, 1'b1);
      check_eq("bp_no_accept", bus.awready, 1'b0);
    end
    b_take(rsp);
    check_eq("bp_bresp1", rsp, 2'b00);
    lat = 0;
    while (!bus.awready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp_second_accept", bus.awready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    b_take(rsp);
    check_eq("bp_bresp2", rsp, 2'b00);
    read_reg(6'h08, rd, rsp);
    check_eq("bp_rd_first", rd, 32'h11);
    read_reg(6'h0C, rd, rsp);
    check_eq("bp_rd_second", rd, 32'h22);

    // Read back-pressure with a concurrent write to the same register
    ar_issue(6'h00);
    check_eq("rs_rvalid", bus.rvalid, 1'b1);
    check_eq("rs_rdata", bus.rdata, 32'h1);
    write_reg(6'h00, 32'h55, 4'hF, rsp);
    check_eq("rs_write_ok", rsp, 2'b00);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!bus.rvalid || bus.rdata !== 32'h1) saw = 1'b1;
    end
    check_eq("rs_stable", saw, 1'b0);
    r_take(rd, rsp);
    check_eq("rs_rd_held", rd, 32'h1);
    read_reg(6'h00, rd, rsp);
    check_eq("rs_rd_new", rd, 32'h55);

    // Reset while a write response is outstanding
    aw_issue(6'h04, 32'h99, 4'hF, lat);
    check_eq("rr_bvalid_pre", bus.bvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check_eq("rr_bvalid_drop", bus.bvalid, 1'b0);
    check_eq("rr_ctrl_zero", ctrl_out, 128'h0);
    check_eq("rr_irq_zero", irq, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    aresetn = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.bvalid || bus.rvalid) saw = 1'b1;
    end
    check_eq("rr_no_resp", saw, 1'b0);
    read_reg(6'h04, rd, rsp);
    check_eq("rr_rd_reset_val", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
